mem_arbiter: RTL and testbench

- Arbitrates NCH processor memory channels (e.g. instruction fetch and load/store) onto one shared memory port with a req/rdy/valid handshake.
- Sits between the core's per-channel request outputs and a unified memory.
- Selectable round-robin or fixed-priority arbitration.
- One outstanding transaction at a time, with a response watchdog.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between NCH requesting channels.
// One transaction in flight at a time (IDLE -> ISSUE -> WAIT -> RESP).
// Arbitration is round-robin or fixed priority. A watchdog aborts a WAIT
// that receives no response within TIMEOUT cycles.
module mem_arbiter #(
    parameter int NBITS     = 32,
    parameter int NCH       = 2,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req_i,
    input  logic [NCH*NBITS-1:0] addr_i,
    input  logic [NCH*NBITS-1:0] wdata_i,
    input  logic [NCH-1:0]       wen_i,
    output logic [NCH-1:0]       rdy_o,
    output logic [NCH-1:0]       valid_o,
    output logic [NCH-1:0]       err_o,
    output logic [NBITS-1:0]     rdata_o,
    output logic                 mem_req,
    output logic [NBITS-1:0]     mem_addr,
    output logic [NBITS-1:0]     mem_wdata,
    output logic                 mem_wen,
    input  logic                 mem_rdy,
    input  logic                 mem_valid,
    input  logic [NBITS-1:0]     mem_rdata,
    output logic                 busy
);

    localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW  = GW + 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Watchdog value in the last permitted WAIT cycle; timeout fires after it.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  PTR_RST = GW'(NCH - 1);
    localparam logic [SW-1:0]  NCH_W   = SW'(NCH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [NBITS-1:0]  addr_q, addr_d;
    logic [NBITS-1:0]  wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic [NBITS-1:0]  rdata_q, rdata_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic              err_q, err_d;

    logic [NBITS-1:0]  addr_arr  [NCH];
    logic [NBITS-1:0]  wdata_arr [NCH];
    logic [NCH-1:0]    req_rot;
    logic [SW-1:0]     shamt;
    logic [SW-1:0]     win_sum;
    logic [GW-1:0]     first_k;
    logic [GW-1:0]     winner;
    logic [NCH-1:0]    gnt_onehot;

    // Unpack the flat per-channel buses into arrays indexed by channel.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr_i[gi*NBITS +: NBITS];
            assign wdata_arr[gi] = wdata_i[gi*NBITS +: NBITS];
        end
    endgenerate

    // Rotate requests so the search starts at ptr+1 (round-robin) or at 0
    // (fixed priority); the doubled vector makes the rotation a plain shift.
    assign shamt   = (PRIO_MODE != 0) ? '0 : ({1'b0, ptr_q} + 1'b1);
    assign req_rot = NCH'({req_i, req_i} >> shamt);

    // Pick the first asserted request in rotated order and map it back to a channel.
    always_comb begin
        first_k = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_rot[i]) first_k = GW'(i);
        end
        win_sum = shamt + {1'b0, first_k};
        if (win_sum >= NCH_W) win_sum = win_sum - NCH_W;
        winner = win_sum[GW-1:0];
    end

    // Next-state logic for the transaction FSM, latched request and watchdog.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        wd_d    = wd_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = winner;
                    ptr_d   = winner;
                    addr_d  = addr_arr[winner];
                    wdata_d = wdata_arr[winner];
                    wen_d   = wen_i[winner];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Backpressure is unbounded here; the watchdog only runs in WAIT.
                if (mem_rdy) begin
                    wd_d    = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response arriving in the timeout cycle takes precedence.
                if (mem_valid) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_RST;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    assign gnt_onehot = NCH'(1) << gnt_q;
    assign rdy_o      = (state_q == ISSUE && mem_rdy) ? gnt_onehot : '0;
    assign valid_o    = (state_q == RESP) ? gnt_onehot : '0;
    assign err_o      = err_q ? gnt_onehot : '0;
    assign rdata_o    = rdata_q;
    assign mem_req    = (state_q == ISSUE);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wen    = wen_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (TIMEOUT=4) and a
// fixed-priority instance share all inputs; a mux picks which one is checked.
module tb_mem_arbiter;

    localparam int NBITS = 32;
    localparam int NCH   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [NCH-1:0]       req_i;
    logic [NCH*NBITS-1:0] addr_i;
    logic [NCH*NBITS-1:0] wdata_i;
    logic [NCH-1:0]       wen_i;
    logic                 mem_rdy;
    logic                 mem_valid;
    logic [NBITS-1:0]     mem_rdata;

    logic [NCH-1:0]   rr_rdy, rr_valid, rr_err, fp_rdy, fp_valid, fp_err;
    logic [NBITS-1:0] rr_rdata, rr_maddr, rr_mwdata, fp_rdata, fp_maddr, fp_mwdata;
    logic             rr_mreq, rr_mwen, rr_busy, fp_mreq, fp_mwen, fp_busy;

    mem_arbiter #(.NBITS(NBITS), .NCH(NCH), .PRIO_MODE(0), .TIMEOUT(4)) u_rr (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .wen_i(wen_i), .rdy_o(rr_rdy), .valid_o(rr_valid), .err_o(rr_err),
        .rdata_o(rr_rdata), .mem_req(rr_mreq), .mem_addr(rr_maddr),
        .mem_wdata(rr_mwdata), .mem_wen(rr_mwen), .mem_rdy(mem_rdy),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .busy(rr_busy)
    );

    mem_arbiter #(.NBITS(NBITS), .NCH(NCH), .PRIO_MODE(1), .TIMEOUT(255)) u_fp (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .wen_i(wen_i), .rdy_o(fp_rdy), .valid_o(fp_valid), .err_o(fp_err),
        .rdata_o(fp_rdata), .mem_req(fp_mreq), .mem_addr(fp_maddr),
        .mem_wdata(fp_mwdata), .mem_wen(fp_mwen), .mem_rdy(mem_rdy),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .busy(fp_busy)
    );

    logic             use_fp;
    logic [NCH-1:0]   o_rdy, o_valid, o_err;
    logic [NBITS-1:0] o_rdata, o_maddr, o_mwdata;
    logic             o_mreq, o_mwen, o_busy;

    assign o_rdy    = use_fp ? fp_rdy    : rr_rdy;
    assign o_valid  = use_fp ? fp_valid  : rr_valid;
    assign o_err    = use_fp ? fp_err    : rr_err;
    assign o_rdata  = use_fp ? fp_rdata  : rr_rdata;
    assign o_maddr  = use_fp ? fp_maddr  : rr_maddr;
    assign o_mwdata = use_fp ? fp_mwdata : rr_mwdata;
    assign o_mreq   = use_fp ? fp_mreq   : rr_mreq;
    assign o_mwen   = use_fp ? fp_mwen   : rr_mwen;
    assign o_busy   = use_fp ? fp_busy   : rr_busy;

    typedef struct {
        logic [NCH-1:0]   req;
        logic             ri;
        logic             vi;
        logic [NBITS-1:0] rd;
        logic [NCH-1:0]   e_rdy;
        logic [NCH-1:0]   e_valid;
        logic [NCH-1:0]   e_err;
        logic             e_mreq;
        logic             e_busy;
        int               e_ch;
        logic [NBITS-1:0] e_rdata;
    } vec_t;

    vec_t             vq[$];
    logic [NBITS-1:0] ch_addr  [NCH];
    logic [NBITS-1:0] ch_wdata [NCH];
    int               checks = 0;
    int               errors = 0;
    int               rdy_cnt   [NCH];
    int               valid_cnt [NCH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t row(input logic [NCH-1:0] req, input logic ri, input logic vi,
                                 input logic [NBITS-1:0] rd, input logic [NCH-1:0] er,
                                 input logic [NCH-1:0] ev, input logic [NCH-1:0] ee,
                                 input logic em, input logic eb, input int ech,
                                 input logic [NBITS-1:0] erd);
        vec_t v;
        v.req = req; v.ri = ri; v.vi = vi; v.rd = rd;
        v.e_rdy = er; v.e_valid = ev; v.e_err = ee; v.e_mreq = em; v.e_busy = eb;
        v.e_ch = ech; v.e_rdata = erd;
        return v;
    endfunction

    // Zero-latency transaction: IDLE, ISSUE (accepted), WAIT (response), RESP.
    task automatic add_txn(input logic [NCH-1:0] req, input int g,
                           input logic [NBITS-1:0] data, input logic [NBITS-1:0] prev);
        logic [NCH-1:0] oh;
        oh = NCH'(1) << g;
        vq.push_back(row(req, 1'b0, 1'b0, '0,   '0, '0, '0, 1'b0, 1'b0, g, prev));
        vq.push_back(row(req, 1'b1, 1'b0, '0,   oh, '0, '0, 1'b1, 1'b1, g, prev));
        vq.push_back(row(req, 1'b0, 1'b1, data, '0, '0, '0, 1'b0, 1'b1, g, prev));
        vq.push_back(row(req, 1'b0, 1'b0, '0,   '0, oh, '0, 1'b0, 1'b1, g, data));
    endtask

    // Drive one cycle's inputs after the falling edge, then check outputs before the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        req_i = v.req; mem_rdy = v.ri; mem_valid = v.vi; mem_rdata = v.rd;
        #1;
        $display("%s req=%b rdy=%b valid=%b err=%b mreq=%b busy=%b rdata=%h",
                 tag, req_i, o_rdy, o_valid, o_err, o_mreq, o_busy, o_rdata);
        chk({tag, " rdy_o"},   32'(o_rdy),   32'(v.e_rdy));
        chk({tag, " valid_o"}, 32'(o_valid), 32'(v.e_valid));
        chk({tag, " err_o"},   32'(o_err),   32'(v.e_err));
        chk({tag, " mem_req"}, 32'(o_mreq),  32'(v.e_mreq));
        chk({tag, " busy"},    32'(o_busy),  32'(v.e_busy));
        chk({tag, " rdata_o"}, o_rdata,      v.e_rdata);
        if (v.e_mreq) begin
            chk({tag, " mem_addr"},  o_maddr,      ch_addr[v.e_ch]);
            chk({tag, " mem_wdata"}, o_mwdata,     ch_wdata[v.e_ch]);
            chk({tag, " mem_wen"},   32'(o_mwen),  32'(wen_i[v.e_ch]));
        end
    endtask

    task automatic run_table(input string tag, input int lo, input int hi);
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], $sformatf("%s[%0d]", tag, i));
            if (i >= lo && i < hi) begin
                for (int c = 0; c < NCH; c++) begin
                    rdy_cnt[c]   += int'(o_rdy[c]);
                    valid_cnt[c] += int'(o_valid[c]);
                end
            end
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_req"}, 32'(o_mreq),  32'(0));
        chk({tag, " busy"},    32'(o_busy),  32'(0));
        chk({tag, " rdy_o"},   32'(o_rdy),   32'(0));
        chk({tag, " valid_o"}, 32'(o_valid), 32'(0));
        chk({tag, " err_o"},   32'(o_err),   32'(0));
        chk({tag, " rdata_o"}, o_rdata,      32'(0));
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0; req_i = '0; mem_rdy = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ch_addr[0]  = 32'h0000_0200; ch_addr[1]  = 32'h0000_0100;
        ch_wdata[0] = 32'h1111_2222; ch_wdata[1] = 32'h3333_4444;
        addr_i  = {ch_addr[1], ch_addr[0]};
        wdata_i = {ch_wdata[1], ch_wdata[0]};
        wen_i   = 2'b01;
        for (int c = 0; c < NCH; c++) begin rdy_cnt[c] = 0; valid_cnt[c] = 0; end
        rst = 1'b0; req_i = '0; mem_rdy = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        use_fp = 1'b0;

        // Reset values, both instances.
        #3;
        chk_quiet("reset_rr");
        chk("reset mem_addr", rr_maddr, 32'(0));
        use_fp = 1'b1; #1;
        chk_quiet("reset_fp");
        use_fp = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Round-robin table: single read on ch1, four contended transactions, backpressure.
        vq.delete();
        vq.push_back(row(2'b10, 1'b0, 1'b0, '0,           '0,    '0,    '0, 1'b0, 1'b0, 1, 32'h0));
        vq.push_back(row(2'b10, 1'b1, 1'b0, '0,           2'b10, '0,    '0, 1'b1, 1'b1, 1, 32'h0));
        vq.push_back(row(2'b00, 1'b0, 1'b0, '0,           '0,    '0,    '0, 1'b0, 1'b1, 1, 32'h0));
        vq.push_back(row(2'b00, 1'b0, 1'b1, 32'hDEADBEEF, '0,    '0,    '0, 1'b0, 1'b1, 1, 32'h0));
        vq.push_back(row(2'b00, 1'b0, 1'b0, '0,           '0,    2'b10, '0, 1'b0, 1'b1, 1, 32'hDEADBEEF));
        vq.push_back(row(2'b00, 1'b0, 1'b0, '0,           '0,    '0,    '0, 1'b0, 1'b0, 1, 32'hDEADBEEF));
        add_txn(2'b11, 0, 32'hA000_0001, 32'hDEADBEEF);
        add_txn(2'b11, 1, 32'hA000_0002, 32'hA000_0001);
        add_txn(2'b11, 0, 32'hA000_0003, 32'hA000_0002);
        add_txn(2'b11, 1, 32'hA000_0004, 32'hA000_0003);
        vq.push_back(row(2'b01, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 0, 32'hA000_0004));
        for (int k = 0; k < 10; k++)
            vq.push_back(row(2'b01, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 0, 32'hA000_0004));
        vq.push_back(row(2'b01, 1'b1, 1'b0, '0,           2'b01, '0,    '0, 1'b1, 1'b1, 0, 32'hA000_0004));
        vq.push_back(row(2'b00, 1'b0, 1'b1, 32'hCAFE0001, '0,    '0,    '0, 1'b0, 1'b1, 0, 32'hA000_0004));
        vq.push_back(row(2'b00, 1'b0, 1'b0, '0,           '0,    2'b01, '0, 1'b0, 1'b1, 0, 32'hCAFE0001));
        run_table("rr", 6, 22);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("rr ch%0d rdy pulses", c),   32'(rdy_cnt[c]),   32'(2));
            chk($sformatf("rr ch%0d valid pulses", c), 32'(valid_cnt[c]), 32'(2));
        end

        // Fixed priority: ch0 wins while it requests; ch1 only after ch0 drops.
        reset_pulse();
        use_fp = 1'b1;
        vq.delete();
        add_txn(2'b11, 0, 32'hB000_0001, 32'h0);
        add_txn(2'b11, 0, 32'hB000_0002, 32'hB000_0001);
        add_txn(2'b11, 0, 32'hB000_0003, 32'hB000_0002);
        add_txn(2'b10, 1, 32'hB000_0004, 32'hB000_0003);
        run_table("fp", 0, 0);
        use_fp = 1'b0;

        // Timeout (TIMEOUT=4): err_o in the 5th cycle after entering WAIT.
        reset_pulse();
        apply(row(2'b01, 1'b0, 1'b0, '0, '0,    '0, '0, 1'b0, 1'b0, 0, 32'h0), "to idle");
        apply(row(2'b01, 1'b1, 1'b0, '0, 2'b01, '0, '0, 1'b1, 1'b1, 0, 32'h0), "to issue");
        for (int k = 1; k <= 4; k++)
            apply(row(2'b00, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 0, 32'h0),
                  $sformatf("to wait%0d", k));
        apply(row(2'b00, 1'b0, 1'b1, 32'hBAD0BAD0, '0, '0, 2'b01, 1'b0, 1'b0, 0, 32'h0), "to err");
        apply(row(2'b00, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 0, 32'h0), "to after");
        // Next request served normally; response arrives in the timeout cycle and wins.
        apply(row(2'b10, 1'b0, 1'b0, '0, '0,    '0, '0, 1'b0, 1'b0, 1, 32'h0), "late idle");
        apply(row(2'b10, 1'b1, 1'b0, '0, 2'b10, '0, '0, 1'b1, 1'b1, 1, 32'h0), "late issue");
        for (int k = 1; k <= 3; k++)
            apply(row(2'b00, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1, 32'h0),
                  $sformatf("late wait%0d", k));
        apply(row(2'b00, 1'b0, 1'b1, 32'h600DF00D, '0, '0, '0, 1'b0, 1'b1, 1, 32'h0), "late wait4");
        apply(row(2'b00, 1'b0, 1'b0, '0, '0, 2'b10, '0, 1'b0, 1'b1, 1, 32'h600DF00D), "late resp");
        apply(row(2'b00, 1'b0, 1'b0, '0, '0, '0,    '0, 1'b0, 1'b0, 1, 32'h600DF00D), "late done");

        // Reset while in WAIT discards the transaction and clears rdata_o.
        apply(row(2'b10, 1'b0, 1'b0, '0, '0,    '0, '0, 1'b0, 1'b0, 1, 32'h600DF00D), "rw idle");
        apply(row(2'b10, 1'b1, 1'b0, '0, 2'b10, '0, '0, 1'b1, 1'b1, 1, 32'h600DF00D), "rw issue");
        apply(row(2'b00, 1'b0, 1'b0, '0, '0,    '0, '0, 1'b0, 1'b1, 1, 32'h600DF00D), "rw wait");
        #2 rst = 1'b0;
        #1 chk_quiet("rst_in_wait");
        @(negedge clk);
        rst = 1'b1;
        apply(row(2'b11, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 0, 32'h0), "post idle");
        apply(row(2'b11, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 0, 32'h0), "post issue");
        // Reset while issuing drops mem_req at once and suppresses rdy_o.
        #2 rst = 1'b0; mem_rdy = 1'b1;
        #1 chk_quiet("rst_in_issue");
        @(negedge clk);
        rst = 1'b1; req_i = '0; mem_rdy = 1'b0;
        apply(row(2'b00, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 0, 32'h0), "final idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
